// File: rtl/vram_port_arbiter_pkg.sv
// rtl/vram_port_arbiter_pkg.sv - shared VRAM geometry, FSM states and address helper
package vram_port_arbiter_pkg;

  localparam int VRAM_W  = 80;
  localparam int VRAM_H  = 60;
  localparam int VRAM_AW = 13;
  localparam int COLOR_W = 3;
  localparam int COORD_W = 16;
  localparam int ENTRY_W = VRAM_AW + COLOR_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2
  } state_t;

  // y*80 + x built from shifts; callers only pass in-range coordinates
  function automatic logic [VRAM_AW-1:0] pixel_addr(input logic [VRAM_AW-1:0] x,
                                                    input logic [VRAM_AW-1:0] y);
    return (y << 6) + (y << 4) + x;
  endfunction

endpackage

// File: rtl/vram_port_arbiter_if.sv
// rtl/vram_port_arbiter_if.sv - CPU write, VGA read and VRAM port signal bundle
interface vram_port_arbiter_if;
  import vram_port_arbiter_pkg::*;

  logic               wr_req;
  logic [COORD_W-1:0] wr_x;
  logic [COORD_W-1:0] wr_y;
  logic [COLOR_W-1:0] wr_color;
  logic               wr_full;
  logic               dropped;
  logic               rd_req;
  logic [6:0]         rd_x;
  logic [5:0]         rd_y;
  logic [COLOR_W-1:0] rd_data;
  logic               rd_valid;
  logic [VRAM_AW-1:0] vram_addr;
  logic               vram_we;
  logic [COLOR_W-1:0] vram_wdata;
  logic [COLOR_W-1:0] vram_rdata;
  logic               starve;

  modport master (
    output wr_req, wr_x, wr_y, wr_color, rd_req, rd_x, rd_y, vram_rdata,
    input  wr_full, dropped, rd_data, rd_valid, vram_addr, vram_we, vram_wdata, starve
  );

  modport slave (
    input  wr_req, wr_x, wr_y, wr_color, rd_req, rd_x, rd_y, vram_rdata,
    output wr_full, dropped, rd_data, rd_valid, vram_addr, vram_we, vram_wdata, starve
  );

endinterface

// File: rtl/vram_wr_fifo.sv
// rtl/vram_wr_fifo.sv - synchronous CPU write buffer, no pass-through when full
module vram_wr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  // a push is refused while full even if the head pops this cycle
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (cnt == (PW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign head    = mem[rd_ptr];

  // storage array, written only on an accepted push
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // pointers wrap naturally at the power-of-two depth; occupancy tracks push minus pop
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/vram_port_arbiter.sv
// rtl/vram_port_arbiter.sv - single-port VRAM sharing, VGA reads win over buffered CPU writes
module vram_port_arbiter
  import vram_port_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_MAX = 255
) (
  input  logic                clk,
  input  logic                resetn,
  vram_port_arbiter_if.slave  bus
);

  localparam int CW = $clog2(FIFO_DEPTH);
  localparam int SW = $clog2(STARVE_MAX + 1);

  state_t             state;
  state_t             next_state;
  logic               in_range;
  logic               accept;
  logic               push;
  logic [ENTRY_W-1:0] push_data;
  logic [ENTRY_W-1:0] head;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CW:0]        fifo_count;
  logic               avail;
  logic [VRAM_AW-1:0] rd_addr_q;
  logic [VRAM_AW-1:0] addr_q;
  logic               we_q;
  logic [COLOR_W-1:0] wdata_q;
  logic               rd_issued;
  logic               rd_valid_q;
  logic               dropped_q;
  logic [SW-1:0]      starve_cnt;

  assign in_range  = (bus.wr_x < COORD_W'(VRAM_W)) && (bus.wr_y < COORD_W'(VRAM_H));
  assign accept    = bus.wr_req && !fifo_full;
  assign push      = accept && in_range;
  assign push_data = {pixel_addr(bus.wr_x[VRAM_AW-1:0], bus.wr_y[VRAM_AW-1:0]), bus.wr_color};

  vram_wr_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(ENTRY_W)) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (push),
    .push_data (push_data),
    .pop       (state == ST_WR),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // entries still waiting once the head being written this cycle is gone
  assign avail = (state == ST_WR) ? (fifo_count > (CW+1)'(1)) : !fifo_empty;

  // state register: the state names what the VRAM port does next cycle
  always_ff @(posedge clk) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= next_state;
  end

  // grant decision is the same from every state: VGA read first, then drain the buffer
  always_comb begin
    next_state = ST_IDLE;
    if (bus.rd_req)  next_state = ST_RD;
    else if (avail)  next_state = ST_WR;
  end

  // registered VRAM port plus read-valid and drop pulses
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_addr_q  <= '0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      rd_issued  <= 1'b0;
      rd_valid_q <= 1'b0;
      dropped_q  <= 1'b0;
    end else begin
      we_q       <= 1'b0;
      rd_issued  <= 1'b0;
      rd_valid_q <= rd_issued;
      dropped_q  <= accept && !in_range;
      if (bus.rd_req) rd_addr_q <= pixel_addr({6'b0, bus.rd_x}, {7'b0, bus.rd_y});
      case (state)
        ST_RD: begin
          addr_q    <= rd_addr_q;
          rd_issued <= 1'b1;
        end
        ST_WR: begin
          addr_q  <= head[ENTRY_W-1:COLOR_W];
          wdata_q <= head[COLOR_W-1:0];
          we_q    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // starvation: count read grants while writes wait, clear on a write grant or nothing waiting
  always_ff @(posedge clk) begin
    if (!resetn) begin
      starve_cnt <= '0;
    end else if (!avail || next_state == ST_WR) begin
      starve_cnt <= '0;
    end else if (next_state == ST_RD && starve_cnt != SW'(STARVE_MAX)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  assign bus.wr_full    = fifo_full;
  assign bus.dropped    = dropped_q;
  assign bus.vram_addr  = addr_q;
  assign bus.vram_we    = we_q;
  assign bus.vram_wdata = wdata_q;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.rd_data    = rd_valid_q ? bus.vram_rdata : '0;
  assign bus.starve     = (starve_cnt == SW'(STARVE_MAX));

endmodule

// File: tb/tb_vram_port_arbiter.sv
// tb/tb_vram_port_arbiter.sv - scoreboard bench for vram_port_arbiter
`timescale 1ns/1ps
module tb_vram_port_arbiter;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  vram_port_arbiter_if bus();

  vram_port_arbiter #(.FIFO_DEPTH(4), .STARVE_MAX(255)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  typedef struct {
    int addr;
    int color;
    int due;
  } exp_t;

  exp_t wq[$];
  exp_t rq[$];
  int   drops_pending = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   last_addr = 0;
  int   last_we = 0;

  // VRAM content seen by the read port: a fixed pattern of the address
  function automatic int vram_f(input int a);
    return (a ^ (a >> 3) ^ (a >> 6)) & 7;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) bus.vram_rdata <= 3'(vram_f(int'(bus.vram_addr)));

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // monitor: every VRAM write, read result and drop pulse must match the next expectation
  always @(negedge clk) begin : monitor
    exp_t e;
    if (bus.vram_we === 1'b1) begin
      if (wq.size() == 0) check("unexpected_we", 1, 0);
      else begin
        e = wq.pop_front();
        check("wr_addr", int'(bus.vram_addr), e.addr);
        check("wr_color", int'(bus.vram_wdata), e.color);
        if (e.due >= 0) check("wr_latency", cyc, e.due);
      end
    end
    if (bus.rd_valid === 1'b1) begin
      if (rq.size() == 0) check("unexpected_rd_valid", 1, 0);
      else begin
        e = rq.pop_front();
        check("rd_addr", last_addr, e.addr);
        check("rd_prev_we", last_we, 0);
        check("rd_data", int'(bus.rd_data), e.color);
        check("rd_latency", cyc, e.due);
      end
    end
    if (bus.dropped === 1'b1) begin
      if (drops_pending == 0) check("unexpected_drop", 1, 0);
      else drops_pending--;
    end
    last_addr = int'(bus.vram_addr);
    last_we   = (bus.vram_we === 1'b1) ? 1 : 0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // drive one cycle of requests and record what the reference rules predict
  task automatic drive(input bit rd, input int rx, input int ry,
                       input bit wr, input int wx, input int wy, input int wc,
                       input bit exp_acc, input bit chk_wlat);
    exp_t e;
    bus.rd_req   = rd;
    bus.rd_x     = 7'(rx);
    bus.rd_y     = 6'(ry);
    bus.wr_req   = wr;
    bus.wr_x     = 16'(wx);
    bus.wr_y     = 16'(wy);
    bus.wr_color = 3'(wc);
    if (rd) begin
      e.addr  = ry * 80 + rx;
      e.color = vram_f(e.addr);
      e.due   = cyc + 3;
      rq.push_back(e);
    end
    if (wr && exp_acc) begin
      if (wx < 80 && wy < 60) begin
        e.addr  = wy * 80 + wx;
        e.color = wc;
        e.due   = chk_wlat ? cyc + 3 : -1;
        wq.push_back(e);
      end else begin
        drops_pending++;
      end
    end
    tick();
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic drain(input string name);
    int k = 0;
    while ((wq.size() != 0 || rq.size() != 0 || drops_pending != 0) && k < 60) begin
      idle(1);
      k++;
    end
    check({name, "_wq_left"}, wq.size(), 0);
    check({name, "_rq_left"}, rq.size(), 0);
    check({name, "_drops_left"}, drops_pending, 0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    int acc;
    bus.rd_req = 0; bus.rd_x = 0; bus.rd_y = 0;
    bus.wr_req = 0; bus.wr_x = 0; bus.wr_y = 0; bus.wr_color = 0;
    resetn = 1'b0;
    tick();
    tick();
    check("reset_we", int'(bus.vram_we), 0);
    check("reset_addr", int'(bus.vram_addr), 0);
    check("reset_full", int'(bus.wr_full), 0);
    check("reset_rd_valid", int'(bus.rd_valid), 0);
    check("reset_dropped", int'(bus.dropped), 0);
    check("reset_starve", int'(bus.starve), 0);
    resetn = 1'b1;
    idle(2);

    // single red write into an idle arbiter
    drive(0, 0, 0, 1, 10, 2, 3'b100, 1, 1);
    idle(5);
    drain("t1");

    // bottom-right read: address visible one edge after the request is taken
    drive(1, 79, 59, 0, 0, 0, 0, 0, 0);
    idle(1);
    check("rd_corner_addr", int'(bus.vram_addr), 4799);
    idle(3);

    // out-of-range writes are dropped without touching VRAM
    drive(0, 0, 0, 1, 80, 0, 5, 1, 0);
    drive(0, 0, 0, 1, 0, 60, 6, 1, 0);
    idle(5);
    check("drops_done", drops_pending, 0);

    // continuous reads starve four buffered writes; the fifth is refused
    acc = 0;
    for (int i = 0; i < 300; i++) begin
      bit w;
      bit ex;
      w  = (i < 5);
      ex = w && (acc < 4);
      if (ex) acc++;
      drive(1, $urandom_range(0, 79), $urandom_range(0, 59), w, i, i, i + 1, ex, 0);
      if (i == 4)   check("full_with_4", int'(bus.wr_full), 1);
      if (i == 254) check("starve_254", int'(bus.starve), 0);
      if (i == 255) check("starve_255", int'(bus.starve), 1);
      if (i == 299) check("starve_hold", int'(bus.starve), 1);
    end
    drain("t2");
    check("starve_cleared", int'(bus.starve), 0);
    check("full_cleared", int'(bus.wr_full), 0);

    // reset discards queued writes and in-flight reads
    for (int i = 0; i < 3; i++)
      drive(1, i, i, 1, 20 + i, 10 + i, i + 2, 1, 0);
    drive(1, 3, 3, 0, 0, 0, 0, 0, 0);
    resetn = 1'b0;
    idle(1);
    check("rst_mid_full", int'(bus.wr_full), 0);
    check("rst_mid_we", int'(bus.vram_we), 0);
    check("rst_mid_rd_valid", int'(bus.rd_valid), 0);
    check("rst_mid_starve", int'(bus.starve), 0);
    wq.delete();
    rq.delete();
    drops_pending = 0;
    resetn = 1'b1;
    idle(10);

    // read and write together into an empty buffer: read first, write the cycle after
    drive(1, 5, 5, 1, 7, 3, 2, 1, 1);
    idle(4);
    drive(1, 40, 30, 1, 79, 59, 7, 1, 0);
    drive(0, 0, 0, 1, 0, 0, 1, 1, 0);
    drive(1, 0, 0, 1, 1, 1, 6, 1, 0);
    drain("t6");

    // randomized mix; the CPU side only requests when the buffer has room
    for (int i = 0; i < 400; i++) begin
      bit rd;
      bit wr;
      rd = ($urandom_range(0, 9) < 6);
      wr = ($urandom_range(0, 1) == 1) && (bus.wr_full == 1'b0);
      drive(rd, $urandom_range(0, 79), $urandom_range(0, 59),
            wr, $urandom_range(0, 90), $urandom_range(0, 70), $urandom_range(0, 7), 1, 0);
    end
    drain("rand");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
